// File: rtl/sa_skew_feeder.sv
// Vector buffer plus diagonal skew register chains feeding the systolic array's subject inputs.
// Lane i of each popped vector reaches subject_out i cycles after lane 0.
module sa_skew_feeder #(
   parameter int N     = 4,
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N*DW-1:0]                in_data,
   input  logic                           start,
   output logic [N*DW-1:0]                subject_out,
   output logic [N-1:0]                   lane_valid,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int DRN_W = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t             state_reg;
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [DRN_W-1:0]   drain_reg;
   logic               busy_reg;
   logic               done_reg;
   logic [N*DW-1:0]    mem [DEPTH];
   logic [N*DW-1:0]    rd_data_reg;
   logic               rd_valid_reg;
   logic               wr_en;
   logic               pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign in_ready = (state_reg == IDLE) && (count_reg < CNT_W'(DEPTH));
   assign wr_en    = in_valid && in_ready;
   assign pop      = (state_reg == STREAM);
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign count    = count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         drain_reg  <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (wr_en && !pop)      count_reg <= count_reg + CNT_W'(1);
         else if (pop && !wr_en) count_reg <= count_reg - CNT_W'(1);

         case (state_reg)
            IDLE: begin
               // A same-cycle write counts toward the tile being started.
               if (start && ((count_reg != '0) || wr_en)) begin
                  state_reg <= STREAM;
                  busy_reg  <= 1'b1;
               end
            end
            STREAM: begin
               if (count_reg == CNT_W'(1)) begin
                  state_reg <= DRAIN;
                  drain_reg <= '0;
               end
            end
            DRAIN: begin
               // N+1 cycles: N to flush the longest chain, one more for the done pulse.
               drain_reg <= drain_reg + DRN_W'(1);
               if (drain_reg == DRN_W'(N - 1)) done_reg <= 1'b1;
               if (drain_reg == DRN_W'(N)) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= in_data;
   end

   // Registered read doubles as the first skew stage shared by every lane.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= pop;
         rd_data_reg  <= pop ? mem[rd_ptr_reg] : '0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         if (gi == 0) begin : g_head
            assign subject_out[DW*gi +: DW] = rd_data_reg[DW*gi +: DW];
            assign lane_valid[gi]           = rd_valid_reg;
         end else begin : g_delay
            logic [DW-1:0] data_reg  [gi];
            logic          valid_reg [gi];

            always_ff @(posedge clk) begin
               if (reset) begin
                  for (int s = 0; s < gi; s++) begin
                     data_reg[s]  <= '0;
                     valid_reg[s] <= 1'b0;
                  end
               end else begin
                  data_reg[0]  <= rd_data_reg[DW*gi +: DW];
                  valid_reg[0] <= rd_valid_reg;
                  for (int s = 1; s < gi; s++) begin
                     data_reg[s]  <= data_reg[s-1];
                     valid_reg[s] <= valid_reg[s-1];
                  end
               end
            end

            assign subject_out[DW*gi +: DW] = data_reg[gi-1];
            assign lane_valid[gi]           = valid_reg[gi-1];
         end
      end
   endgenerate

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: scoreboard of skewed elements built at tile start,
// popped and compared cycle by cycle against subject_out, plus status checks.
module tb_sa_skew_feeder;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [N*DW-1:0]   in_data;
   logic              start;
   logic [N*DW-1:0]   subject_out;
   logic [N-1:0]      lane_valid;
   logic              busy;
   logic              done;
   logic [CW-1:0]     count;

   sa_skew_feeder #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .start(start), .subject_out(subject_out),
      .lane_valid(lane_valid), .busy(busy), .done(done), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      int            lane;
      logic [DW-1:0] data;
   } exp_t;

   exp_t            exp_q[$];
   int              done_q[$];
   logic [N*DW-1:0] buf_q[$];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int c0     = 0;
   int tile_l = 0;
   bit active = 1'b0;
   bit armed  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
      end
   endtask

   // Model and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      bit              exp_busy;
      bit              exp_done;
      bit              exp_rdy;
      int              exp_cnt;
      logic [N-1:0]    exp_vld;
      logic [N*DW-1:0] exp_dat;
      logic [N*DW-1:0] vec;
      exp_t            e;
      if (reset) begin
         exp_q.delete();
         done_q.delete();
         buf_q.delete();
         active = 1'b0;
         armed  = 1'b1;
      end else if (armed) begin
         exp_busy = active && (cyc >= c0 + 1) && (cyc <= c0 + tile_l + N + 1);
         exp_done = 1'b0;
         if (done_q.size() > 0 && done_q[0] == cyc) begin
            exp_done = 1'b1;
            void'(done_q.pop_front());
         end
         exp_vld = '0;
         exp_dat = '0;
         while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            exp_vld[e.lane] = 1'b1;
            exp_dat[e.lane*DW +: DW] = e.data;
         end
         if (active && cyc >= c0 + 1 && cyc <= c0 + tile_l) exp_cnt = tile_l - (cyc - c0 - 1);
         else exp_cnt = buf_q.size();
         exp_rdy = !exp_busy && (exp_cnt < DEPTH);

         check_eq("subject_out", 64'(subject_out), 64'(exp_dat));
         check_eq("lane_valid", 64'(lane_valid), 64'(exp_vld));
         check_eq("busy", 64'(busy), 64'(exp_busy));
         check_eq("done", 64'(done), 64'(exp_done));
         check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
         check_eq("count", 64'(count), 64'(exp_cnt));

         if (in_valid && exp_rdy) buf_q.push_back(in_data);
         if (start && !exp_busy && buf_q.size() > 0) begin
            c0     = cyc;
            tile_l = buf_q.size();
            active = 1'b1;
            for (int t = 0; t <= tile_l + N - 2; t++) begin
               for (int i = 0; i < N; i++) begin
                  int k;
                  k = t - i;
                  if (k >= 0 && k < tile_l) begin
                     vec = buf_q[k];
                     e.cyc  = c0 + 2 + t;
                     e.lane = i;
                     e.data = vec[i*DW +: DW];
                     exp_q.push_back(e);
                  end
               end
            end
            done_q.push_back(c0 + tile_l + N + 1);
            buf_q.delete();
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_vec(input logic [N*DW-1:0] v);
      in_valid = 1'b1;
      in_data  = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      start    = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) tick();

      // Basic 3-vector tile
      write_vec(32'h04030201);
      write_vec(32'h08070605);
      write_vec(32'h0C0B0A09);
      start_pulse();
      repeat (12) tick();

      // Fill to DEPTH, then a dropped 9th write
      for (int v = 0; v < DEPTH; v++) write_vec(32'h10101010 * (v + 1) + 32'h00010203);
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      repeat (2) tick();
      in_valid = 1'b0;
      start_pulse();
      repeat (18) tick();

      // Start on empty buffer, then write+start same cycle, then start while busy
      start_pulse();
      repeat (3) tick();
      in_valid = 1'b1;
      in_data  = 32'h11223344;
      start    = 1'b1;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      tick();
      start_pulse();
      repeat (10) tick();

      // 5-vector then 6-vector tile, wrapping the pointers
      for (int v = 0; v < 5; v++) write_vec(32'hA0A1A2A3 + 32'h01010101 * v);
      start_pulse();
      repeat (12) tick();
      for (int v = 0; v < 6; v++) write_vec(32'h50617283 ^ (32'h11111111 * (v + 1)));
      start_pulse();
      repeat (13) tick();

      // Abort a 4-vector tile with reset in c0+3
      for (int v = 0; v < 4; v++) write_vec(32'hC1C2C3C4 + 32'h02020202 * v);
      start_pulse();
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (3) tick();

      // Fresh 1-vector tile after the abort
      write_vec(32'h5A6B7C8D);
      start_pulse();
      repeat (10) tick();

      check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
      check_eq("done_q_empty", 64'(done_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
